// File: rtl/dcache_wr_buffer_if.sv
// Write-path bundle between dcache, posted write buffer and the AXI bridge d_wr_* port.
// slave = the buffer's view; master = the environment driving it (dcache + bridge).
interface dcache_wr_buffer_if;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic [31:0]  rd_chk_addr;
  logic         rd_chk_hit;
  logic         b_wr_req;
  logic [2:0]   b_wr_type;
  logic [31:0]  b_wr_addr;
  logic [3:0]   b_wr_wstrb;
  logic [127:0] b_wr_data;
  logic         b_wr_rdy;

  // Handshakes: a transfer happens on a rising edge where req && rdy;
  // req and its payload stay stable until that edge, and rdy never depends on req.
  modport slave (
    input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data, rd_chk_addr, b_wr_rdy,
    output wr_rdy, rd_chk_hit, b_wr_req, b_wr_type, b_wr_addr, b_wr_wstrb, b_wr_data
  );

  modport master (
    output wr_req, wr_type, wr_addr, wr_wstrb, wr_data, rd_chk_addr, b_wr_rdy,
    input  wr_rdy, rd_chk_hit, b_wr_req, b_wr_type, b_wr_addr, b_wr_wstrb, b_wr_data
  );
endinterface

// File: rtl/dcache_wr_buffer.sv
// Posted in-order write buffer between the dcache write port and the AXI bridge,
// with read-after-write line hazard detection and an edge-qualified flush handshake.
module dcache_wr_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  dcache_wr_buffer_if.slave      bus,
  input  logic                   flush_req_i,
  output logic                   flush_done_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   state_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             armed_q, armed_d;

  logic [2:0]   mem_type  [DEPTH];
  logic [31:0]  mem_addr  [DEPTH];
  logic [3:0]   mem_wstrb [DEPTH];
  logic [127:0] mem_data  [DEPTH];

  logic             enq, deq, hit;
  logic [PTR_W-1:0] off;

  assign bus.wr_rdy     = (count_q != CNT_W'(DEPTH)) && (state_q == RUN);
  assign enq            = bus.wr_req && bus.wr_rdy;
  assign bus.b_wr_req   = (count_q != '0);
  assign deq            = bus.b_wr_req && bus.b_wr_rdy;
  assign bus.b_wr_type  = mem_type[rd_ptr_q];
  assign bus.b_wr_addr  = mem_addr[rd_ptr_q];
  assign bus.b_wr_wstrb = mem_wstrb[rd_ptr_q];
  assign bus.b_wr_data  = mem_data[rd_ptr_q];
  assign bus.rd_chk_hit = hit;
  assign empty_o        = (count_q == '0);
  assign count_o        = count_q;
  assign flush_done_o   = done_q;
  assign state_o        = state_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // A flush starts only on a fresh assertion: armed is rebuilt while flush_req is low.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    armed_d = armed_q;
    if (!flush_req_i) armed_d = 1'b1;
    case (state_q)
      RUN: begin
        if (flush_req_i && armed_q) begin
          state_d = FLUSH;
          armed_d = 1'b0;
        end
      end
      FLUSH: begin
        if (count_q == '0) begin
          state_d = RUN;
          done_d  = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // An entry leaving this cycle is still valid here, so it still flags a hazard.
  always_comb begin
    off = '0;
    hit = enq && (bus.wr_addr[31:4] == bus.rd_chk_addr[31:4]);
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr_q;
      if (({1'b0, off} < count_q) && (mem_addr[i][31:4] == bus.rd_chk_addr[31:4]))
        hit = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= RUN;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      armed_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      done_q   <= done_d;
      armed_q  <= armed_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_type[wr_ptr_q]  <= bus.wr_type;
      mem_addr[wr_ptr_q]  <= bus.wr_addr;
      mem_wstrb[wr_ptr_q] <= bus.wr_wstrb;
      mem_data[wr_ptr_q]  <= bus.wr_data;
    end
  end
endmodule
